// File: rtl/multi_tick_gen.sv
// Multi-channel tick generator: shared prescaler feeding per-channel
// divisors, each channel periodic or one-shot with one-cycle strobes.
module multi_tick_gen #(
  parameter int PRESCALE = 10000,
  parameter int N_CH     = 4,
  parameter int DIV_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [N_CH*DIV_W-1:0] div_in,
  input  logic [N_CH-1:0]       mode,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  output logic                  base_tick,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  logic [PW-1:0]    r_pre_cnt;
  logic             w_base;

  state_t           r_state [N_CH];
  state_t           w_state [N_CH];
  logic [DIV_W-1:0] r_cnt   [N_CH];
  logic [DIV_W-1:0] w_cnt   [N_CH];
  logic [DIV_W-1:0] r_div   [N_CH];
  logic [DIV_W-1:0] w_div   [N_CH];
  logic [DIV_W-1:0] w_din   [N_CH];
  logic [N_CH-1:0]  r_mode;
  logic [N_CH-1:0]  w_mode;
  logic [N_CH-1:0]  r_tick;
  logic [N_CH-1:0]  w_tick;
  logic [N_CH-1:0]  r_busy;
  logic [N_CH-1:0]  w_busy;

  // Gated by rst_n so PRESCALE=1 cannot strobe during reset
  assign w_base    = rst_n & en & (r_pre_cnt == PRE_MAX);
  assign base_tick = w_base;
  assign tick      = r_tick;
  assign busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt <= '0;
    end else if (clr) begin
      r_pre_cnt <= '0;
    end else if (en) begin
      r_pre_cnt <= w_base ? '0 : r_pre_cnt + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_din[i]   = div_in[i*DIV_W +: DIV_W];
      w_state[i] = r_state[i];
      w_cnt[i]   = r_cnt[i];
      w_div[i]   = r_div[i];
      w_mode[i]  = r_mode[i];
      w_tick[i]  = 1'b0;
      w_busy[i]  = r_busy[i];
      priority case (1'b1)
        clr, stop[i]: begin
          w_state[i] = S_IDLE;
          w_cnt[i]   = '0;
          w_busy[i]  = 1'b0;
        end
        start[i]: begin
          if (w_din[i] != '0) begin
            w_state[i] = S_RUN;
            w_cnt[i]   = '0;
            w_div[i]   = w_din[i];
            w_mode[i]  = mode[i];
            w_busy[i]  = 1'b1;
          end else begin
            w_state[i] = S_IDLE;
            w_cnt[i]   = '0;
            w_busy[i]  = 1'b0;
          end
        end
        (r_state[i] == S_RUN) && w_base: begin
          if (r_cnt[i] == r_div[i] - 1'b1) begin
            w_tick[i] = 1'b1;
            w_cnt[i]  = '0;
            if (r_mode[i]) begin
              if (w_din[i] != '0) w_div[i] = w_din[i];
            end else begin
              w_state[i] = S_IDLE;
              w_busy[i]  = 1'b0;
            end
          end else begin
            w_cnt[i] = r_cnt[i] + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= '0;
      r_tick <= '0;
      r_busy <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
        r_div[i]   <= '0;
      end
    end else begin
      r_mode <= w_mode;
      r_tick <= w_tick;
      r_busy <= w_busy;
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= w_state[i];
        r_cnt[i]   <= w_cnt[i];
        r_div[i]   <= w_div[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Bench for multi_tick_gen: PRESCALE=4, N_CH=2, DIV_W=8; expected tick
// cycles are queued at start time and consumed as ticks appear.
module tb_multi_tick_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic [15:0] div_in;
  logic [1:0]  mode;
  logic [1:0]  start;
  logic [1:0]  stop;
  logic        base_tick;
  logic [1:0]  tick;
  logic [1:0]  busy;

  multi_tick_gen #(
    .PRESCALE(4),
    .N_CH(2),
    .DIV_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .clr(clr),
    .div_in(div_in),
    .mode(mode),
    .start(start),
    .stop(stop),
    .base_tick(base_tick),
    .tick(tick),
    .busy(busy)
  );

  typedef struct {
    int ch;
    int dv;
    bit md;
    int nt;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int q0[$];
  int q1[$];
  vec_t tbl[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Clear, then land on the negedge where base_tick is high
  task automatic align();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_outputs", {27'd0, tick, busy, base_tick}, 0);
    repeat (3) @(negedge clk);
    chk("pre_phase", {31'd0, base_tick}, 1);
  endtask

  task automatic push(input int ch, input int t);
    if (ch == 0) q0.push_back(t);
    else q1.push_back(t);
  endtask

  always @(negedge clk) begin
    if (tick[0]) begin
      if (q0.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL tick0_unexp: tick at cycle %0d, expected none", cyc);
      end else begin
        chk("tick0_time", cyc, q0.pop_front());
      end
    end
    if (tick[1]) begin
      if (q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL tick1_unexp: tick at cycle %0d, expected none", cyc);
      end else begin
        chk("tick1_time", cyc, q1.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    int per;
    int last;
    int ch;
    tbl[0] = '{0, 3,   1'b1, 3};
    tbl[1] = '{1, 2,   1'b0, 1};
    tbl[2] = '{0, 1,   1'b1, 4};
    tbl[3] = '{1, 1,   1'b0, 1};
    tbl[4] = '{1, 5,   1'b1, 2};
    tbl[5] = '{0, 255, 1'b0, 1};
    tbl[6] = '{1, 0,   1'b1, 0};

    rst_n  = 1'b0;
    en     = 1'b1;
    clr    = 1'b0;
    stop   = 2'b00;
    start  = 2'b11;
    mode   = 2'b11;
    div_in = {8'd2, 8'd3};
    repeat (5) begin
      @(negedge clk);
      chk("rst_hold", {27'd0, tick, busy, base_tick}, 0);
    end
    rst_n = 1'b1;
    start = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("rst_base", {31'd0, base_tick}, (k == 3) ? 1 : 0);
    end

    for (int i = 0; i < 7; i++) begin
      align();
      s  = cyc;
      ch = tbl[i].ch;
      div_in[ch*8 +: 8] = 8'(tbl[i].dv);
      mode[ch]  = tbl[i].md;
      start[ch] = 1'b1;
      per = tbl[i].dv * 4;
      for (int k = 1; k <= tbl[i].nt; k++) push(ch, s + 1 + k * per);
      @(negedge clk);
      start = 2'b00;
      chk("busy_start", {31'd0, busy[ch]}, (tbl[i].dv != 0) ? 1 : 0);
      if (tbl[i].nt > 0) begin
        last = s + 1 + tbl[i].nt * per;
        wait_cyc(last - 1);
        chk("busy_pre", {31'd0, busy[ch]}, 1);
        wait_cyc(last);
        chk("busy_tick", {31'd0, busy[ch]}, {31'd0, tbl[i].md});
      end else begin
        wait_cyc(s + 20);
        chk("busy_div0", {31'd0, busy[ch]}, 0);
      end
      @(negedge clk);
      stop = 2'b11;
      chk("q_empty", q0.size() + q1.size(), 0);
      @(negedge clk);
      stop = 2'b00;
    end

    // Divisor reload: 12, then 20, and a zero divisor keeps 20
    align();
    s = cyc;
    div_in[7:0] = 8'd3;
    mode[0]  = 1'b1;
    start[0] = 1'b1;
    push(0, s + 13);
    push(0, s + 33);
    push(0, s + 53);
    @(negedge clk);
    start = 2'b00;
    wait_cyc(s + 6);
    div_in[7:0] = 8'd5;
    wait_cyc(s + 20);
    div_in[7:0] = 8'd0;
    wait_cyc(s + 54);
    stop = 2'b11;
    chk("reload_q", q0.size(), 0);
    @(negedge clk);
    stop = 2'b00;

    // Enable freeze: 7 low cycles delay the second tick by 7
    align();
    s = cyc;
    div_in[15:8] = 8'd2;
    mode[1]  = 1'b1;
    start[1] = 1'b1;
    push(1, s + 9);
    push(1, s + 24);
    @(negedge clk);
    start = 2'b00;
    wait_cyc(s + 11);
    en = 1'b0;
    wait_cyc(s + 18);
    en = 1'b1;
    wait_cyc(s + 25);
    chk("freeze_q", q1.size(), 0);
    chk("freeze_busy", {30'd0, busy}, 2);
    align();

    // Start and stop together while running
    s = cyc;
    div_in[7:0] = 8'd2;
    mode[0]  = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    start = 2'b00;
    wait_cyc(s + 3);
    start[0] = 1'b1;
    stop[0]  = 1'b1;
    @(negedge clk);
    start = 2'b00;
    stop  = 2'b00;
    chk("startstop_busy", {31'd0, busy[0]}, 0);
    wait_cyc(s + 20);
    chk("startstop_q", q0.size(), 0);

    // Stop on the terminal base tick
    align();
    s = cyc;
    start[0] = 1'b1;
    @(negedge clk);
    start = 2'b00;
    wait_cyc(s + 8);
    stop[0] = 1'b1;
    @(negedge clk);
    stop = 2'b00;
    chk("stopterm_tick", {31'd0, tick[0]}, 0);
    chk("stopterm_busy", {31'd0, busy[0]}, 0);
    wait_cyc(s + 20);
    chk("stopterm_q", q0.size(), 0);

    // Asynchronous reset mid-period
    align();
    s = cyc;
    div_in[15:8] = 8'd3;
    mode[1]  = 1'b1;
    start[1] = 1'b1;
    @(negedge clk);
    start = 2'b00;
    chk("arst_busy_pre", {31'd0, busy[1]}, 1);
    wait_cyc(s + 5);
    #2 rst_n = 1'b0;
    #1 chk("arst_busy", {29'd0, busy, base_tick}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(cyc + 40);
    chk("arst_q", q0.size() + q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
